// File: rtl/lix_pipe_reg.sv
// DEPTH-stage elastic pipeline register with valid/ready on both sides,
// bubble collapsing between stages, and a synchronous flush.
module lix_pipe_reg #(
  parameter  int W     = 32,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          i_flush,
  input  logic          i_vld,
  output logic          o_rdy,
  input  logic [W-1:0]  i_x,
  output logic          o_vld,
  input  logic          i_rdy,
  output logic [W-1:0]  o_z,
  output logic [CW-1:0] o_cnt
);

  logic [DEPTH-1:0] r_v;
  logic [W-1:0]     r_d [DEPTH];
  logic [CW-1:0]    r_cnt;

  logic [DEPTH-1:0] w_adv;
  logic [DEPTH-1:0] w_load;
  logic             w_accept;
  logic             w_out;

  // Stage k moves when some later stage is empty (that gap absorbs the
  // shuffle) or the whole tail is full and draining into i_rdy.
  always_comb begin
    logic w_tail_full;
    w_adv = '0;
    for (int k = 0; k < DEPTH; k++) begin
      w_tail_full = 1'b1;
      for (int j = k + 1; j < DEPTH; j++) begin
        w_tail_full = w_tail_full & r_v[j];
      end
      w_adv[k] = r_v[k] & (~w_tail_full | i_rdy) & ~i_flush;
    end
  end

  assign o_rdy    = (~r_v[0] | w_adv[0]) & ~i_flush;
  assign w_accept = i_vld & o_rdy;
  assign w_out    = w_adv[DEPTH-1];

  always_comb begin
    w_load    = '0;
    w_load[0] = w_accept;
    for (int k = 1; k < DEPTH; k++) begin
      w_load[k] = w_adv[k-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_v   <= '0;
      r_cnt <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else begin
      // Data is only ever written on a transfer; flush leaves it in place.
      r_d[0] <= w_accept ? i_x : r_d[0];
      for (int k = 1; k < DEPTH; k++) begin
        r_d[k] <= w_load[k] ? r_d[k-1] : r_d[k];
      end
      if (i_flush) begin
        r_v   <= '0;
        r_cnt <= '0;
      end else begin
        r_v <= w_load | (r_v & ~w_adv);
        if (w_accept && !w_out) begin
          r_cnt <= r_cnt + CW'(1);
        end else if (w_out && !w_accept) begin
          r_cnt <= r_cnt - CW'(1);
        end
      end
    end
  end

  assign o_vld = r_v[DEPTH-1] & ~i_flush;
  assign o_z   = r_d[DEPTH-1];
  assign o_cnt = r_cnt;

endmodule
